// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the structural ALU.
// Accepts one op per valid/ready handshake, pulses one unit enable,
// waits for that unit's completion flag (or a timeout) and returns the
// captured result on a valid/ready result port.
//
// Ports:
//   CLK_SEQ, RST_SEQ          clock, synchronous active-low reset
//   CMD_VALID/READY/A/B/FUN   command handshake and operands
//   A_OUT, B_OUT, FUN_OUT     registered operands/function to the units
//   *_EN                      one-cycle unit enables (at most one high)
//   *_OUT, *_FLAG             unit results and completion flags
//   RES_VALID/READY/DATA/ERR  result handshake, data and timeout marker
//   ERR_CNT                   saturating count of timeout completions
module alu_op_sequencer #(
    parameter int A_width   = 16,
    parameter int B_width   = 16,
    parameter int OUT_width = 32,
    parameter int TIMEOUT   = 8
) (
    input  logic                 CLK_SEQ,
    input  logic                 RST_SEQ,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [A_width-1:0]   CMD_A,
    input  logic [B_width-1:0]   CMD_B,
    input  logic [3:0]           CMD_FUN,
    output logic [A_width-1:0]   A_OUT,
    output logic [B_width-1:0]   B_OUT,
    output logic [1:0]           FUN_OUT,
    output logic                 ARITH_EN,
    output logic                 LOGIC_EN,
    output logic                 CMP_EN,
    output logic                 SHIFT_EN,
    input  logic [OUT_width-1:0] ARITH_OUT,
    input  logic [OUT_width-1:0] LOGIC_OUT,
    input  logic [OUT_width-1:0] CMP_OUT,
    input  logic [OUT_width-1:0] SHIFT_OUT,
    input  logic                 ARITH_FLAG,
    input  logic                 LOGIC_FLAG,
    input  logic                 CMP_FLAG,
    input  logic                 SHIFT_FLAG,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [OUT_width-1:0] RES_DATA,
    output logic                 RES_ERR,
    output logic [7:0]           ERR_CNT
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [A_width-1:0]   a_q, a_d;
    logic [B_width-1:0]   b_q, b_d;
    logic [1:0]           fun_q, fun_d;
    logic [1:0]           sel_q, sel_d;
    // en bit order: 0 arith, 1 logic, 2 cmp, 3 shift
    logic [3:0]           en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [OUT_width-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic                 sel_flag;
    logic [OUT_width-1:0] sel_out;

    // Only the latched unit is observed; other units' flags are ignored.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        unique case (sel_q)
            2'b00: begin sel_flag = ARITH_FLAG; sel_out = ARITH_OUT; end
            2'b01: begin sel_flag = LOGIC_FLAG; sel_out = LOGIC_OUT; end
            2'b10: begin sel_flag = CMP_FLAG;   sel_out = CMP_OUT;   end
            2'b11: begin sel_flag = SHIFT_FLAG; sel_out = SHIFT_OUT; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        sel_d     = sel_q;
        en_d      = 4'b0000;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    a_d     = CMD_A;
                    b_d     = CMD_B;
                    fun_d   = CMD_FUN[1:0];
                    sel_d   = CMD_FUN[3:2];
                    // Enable is registered so it is high during ISSUE.
                    en_d    = 4'b0001 << CMD_FUN[3:2];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion flag takes priority over a same-cycle timeout.
                if (sel_flag) begin
                    data_d  = sel_out;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SEQ) begin
        if (!RST_SEQ) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            sel_q     <= '0;
            en_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign CMD_READY = (state_q == S_IDLE) & RST_SEQ;
    assign A_OUT     = a_q;
    assign B_OUT     = b_q;
    assign FUN_OUT   = fun_q;
    assign ARITH_EN  = en_q[0];
    assign LOGIC_EN  = en_q[1];
    assign CMP_EN    = en_q[2];
    assign SHIFT_EN  = en_q[3];
    assign RES_VALID = valid_q;
    assign RES_DATA  = data_q;
    assign RES_ERR   = err_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with
// behavioural unit models of programmable completion delay.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_fun;
    logic [15:0] a_out, b_out;
    logic [1:0]  fun_out;
    logic        arith_en, logic_en, cmp_en, shift_en;
    logic [31:0] u_res [4];
    logic        u_flag [4];
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_data;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int dly [4];
    int age [4];
    int en_cnt [4];
    int multi_en = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .A_width(16), .B_width(16), .OUT_width(32), .TIMEOUT(8)
    ) dut (
        .CLK_SEQ(clk), .RST_SEQ(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_FUN(cmd_fun),
        .A_OUT(a_out), .B_OUT(b_out), .FUN_OUT(fun_out),
        .ARITH_EN(arith_en), .LOGIC_EN(logic_en),
        .CMP_EN(cmp_en), .SHIFT_EN(shift_en),
        .ARITH_OUT(u_res[0]), .LOGIC_OUT(u_res[1]),
        .CMP_OUT(u_res[2]), .SHIFT_OUT(u_res[3]),
        .ARITH_FLAG(u_flag[0]), .LOGIC_FLAG(u_flag[1]),
        .CMP_FLAG(u_flag[2]), .SHIFT_FLAG(u_flag[3]),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_DATA(res_data), .RES_ERR(res_err), .ERR_CNT(err_cnt)
    );

    function automatic logic [31:0] calc(input int u, input logic [1:0] f,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
        logic [31:0] aa, bb;
        aa = {16'b0, a};
        bb = {16'b0, b};
        calc = '0;
        case (u)
            0: case (f)
                2'd0: calc = aa + bb;
                2'd1: calc = {16'b0, a - b};
                2'd2: calc = aa + 1;
                default: calc = {16'b0, a - 16'd1};
            endcase
            1: case (f)
                2'd0: calc = aa & bb;
                2'd1: calc = aa | bb;
                2'd2: calc = aa ^ bb;
                default: calc = {16'b0, ~a};
            endcase
            2: case (f)
                2'd0: calc = {31'b0, a == b};
                2'd1: calc = {31'b0, a < b};
                2'd2: calc = {31'b0, a > b};
                default: calc = {31'b0, a != b};
            endcase
            default: case (f)
                2'd0: calc = aa >> 1;
                2'd1: calc = aa << 1;
                2'd2: calc = aa >> b[3:0];
                default: calc = aa << b[3:0];
            endcase
        endcase
    endfunction

    // Unit models: register result on EN, raise flag dly cycles later.
    logic [3:0] en_vec;
    assign en_vec = {shift_en, cmp_en, logic_en, arith_en};

    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (en_vec[u]) begin
                u_res[u] <= calc(u, fun_out, a_out, b_out);
                age[u]   <= 1;
                en_cnt[u] <= en_cnt[u] + 1;
            end else if (age[u] > 0 && age[u] < 1000) begin
                age[u] <= age[u] + 1;
            end
        end
        if ($countones(en_vec) > 1) multi_en <= multi_en + 1;
    end

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            u_flag[u] = (dly[u] != 0) && (age[u] >= dly[u]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] fun, input logic [15:0] a,
                         input logic [15:0] b, input logic terr);
        exp_t e;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_pre got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_fun   = fun;
        cmd_a     = a;
        cmd_b     = b;
        e.data = terr ? 32'h0 : calc(int'(fun[3:2]), fun[1:0], a, b);
        e.err  = terr;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 16'hDEAD;
        cmd_b     = 16'hBEEF;
        cmd_fun   = 4'hF;
    endtask

    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (res_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL res_valid_wait got=%b exp=1 after %0d", res_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_fun = '0;
        res_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_out, b_out, fun_out, en_vec} !== '0) begin
            failures++;
            $display("FAIL reset_cmdregs got=%h exp=0", {a_out, b_out, fun_out, en_vec});
        end
        checks++;
        if ({res_valid, res_data, res_err, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_res got=%h exp=0", {res_valid, res_data, res_err, err_cnt});
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_shift();
        exp_t e;
        int lat, base;
        base = en_cnt[3];
        issue(4'b1101, 16'h00F0, 16'h0000, 1'b0);
        checks++;
        if ({shift_en, cmp_en, logic_en, arith_en} !== 4'b1000) begin
            failures++;
            $display("FAIL shift_en_issue got=%b exp=1000", en_vec);
        end
        checks++;
        if (fun_out !== 2'b01 || a_out !== 16'h00F0) begin
            failures++;
            $display("FAIL shift_operands got=%b/%h exp=01/00f0", fun_out, a_out);
        end
        tick();
        checks++;
        if (en_vec !== 4'b0000 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL shift_wait_en got=%b/%b exp=0000/0", en_vec, cmd_ready);
        end
        wait_result(1, lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL shift_latency got=%0d exp=2", lat);
        end
        e = sb.pop_front();
        checks++;
        if (res_data !== 32'h000001E0 || res_data !== e.data || res_err !== 1'b0) begin
            failures++;
            $display("FAIL shift_result got=%h/%b exp=000001e0/0", res_data, res_err);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (en_cnt[3] - base != 1) begin
            failures++;
            $display("FAIL shift_en_pulses got=%0d exp=1", en_cnt[3] - base);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] funs [3];
        exp_t e;
        int lat, u, base, tot;
        funs[0] = 4'b0000;
        funs[1] = 4'b0110;
        funs[2] = 4'b1001;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u = int'(funs[i][3:2]);
            base = en_cnt[u];
            tot = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
            issue(funs[i], 16'($urandom), 16'($urandom), 1'b0);
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready_issue op=%0d got=%b exp=0", i, cmd_ready);
            end
            wait_result(0, lat);
            e = sb.pop_front();
            checks++;
            if (lat != 2 || res_data !== e.data || res_err !== e.err) begin
                failures++;
                $display("FAIL b2b_result op=%0d got=%0d/%h/%b exp=2/%h/%b",
                         i, lat, res_data, res_err, e.data, e.err);
            end
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready_done op=%0d got=%b exp=0", i, cmd_ready);
            end
            tick();
            checks++;
            if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_release op=%0d got=%b/%b exp=0/1", i, res_valid, cmd_ready);
            end
            checks++;
            if (en_cnt[u] - base != 1 ||
                en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] - tot != 1) begin
                failures++;
                $display("FAIL b2b_en_pulses op=%0d got=%0d exp=1", i, en_cnt[u] - base);
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int lat;
        dly[1] = 0;
        issue(4'b0110, 16'h1234, 16'h5678, 1'b1);
        wait_result(0, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 9 || res_data !== e.data || res_err !== e.err) begin
            failures++;
            $display("FAIL timeout_result got=%0d/%h/%b exp=9/%h/%b",
                     lat, res_data, res_err, e.data, e.err);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL timeout_err_cnt got=%0d exp=1", err_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        dly[1] = 8;
        issue(4'b0101, 16'h0F0F, 16'h3030, 1'b0);
        wait_result(0, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 9 || res_data !== e.data || res_err !== 1'b0) begin
            failures++;
            $display("FAIL flag_last_wait got=%0d/%h/%b exp=9/%h/0",
                     lat, res_data, res_err, e.data);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL flag_last_err_cnt got=%0d exp=1", err_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        dly[1] = 1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        issue(4'b0001, 16'h1234, 16'h0034, 1'b0);
        wait_result(0, lat);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            cmd_a = 16'hAAAA;
            cmd_fun = 4'b1100;
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== e.data ||
                res_err !== e.err || a_out !== 16'h1234) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%h exp=1/%h/%b/1234",
                         i, res_valid, res_data, res_err, a_out, e.data, e.err);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%b/%b exp=0/1", res_valid, cmd_ready);
        end
        tick();
        checks++;
        if (a_out !== 16'h1234 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_after got=%h/%b exp=1234/1", a_out, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        dly[2] = 0;
        issue(4'b1000, 16'h0055, 16'h0055, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({a_out, b_out, fun_out, en_vec, res_valid, res_data, res_err, err_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {a_out, b_out, fun_out, en_vec, res_valid, res_data, res_err, err_cnt});
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ready got=%b exp=0", cmd_ready);
        end
        sb.delete();
        rst_n = 1'b1;
        dly[2] = 1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle got=%b/%b exp=1/0", cmd_ready, res_valid);
        end
        issue(4'b1010, 16'h0900, 16'h0090, 1'b0);
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_stale got=%b exp=0", res_valid);
        end
        wait_result(1, lat);
        e = sb.pop_front();
        checks++;
        if (lat != 2 || res_data !== e.data || res_err !== e.err) begin
            failures++;
            $display("FAIL mid_reset_new got=%0d/%h/%b exp=2/%h/%b",
                     lat, res_data, res_err, e.data, e.err);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        int lat;
        int bad = 0;
        dly[1] = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(4'b0100, 16'($urandom), 16'($urandom), 1'b1);
            wait_result(0, lat);
            e = sb.pop_front();
            if (res_err !== e.err || res_data !== e.data || lat != 9) bad++;
            tick();
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL sat_at_255 got=%0d exp=255", err_cnt);
                end
            end
        end
        res_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sat_results got=%0d bad exp=0", bad);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt);
        end
        checks++;
        if (multi_en != 0) begin
            failures++;
            $display("FAIL one_hot_en got=%0d exp=0", multi_en);
        end
        dly[1] = 1;
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            dly[u]    = 1;
            age[u]    = 0;
            en_cnt[u] = 0;
            u_res[u]  = '0;
        end
        test_reset();
        test_shift();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end for the structural ALU. It accepts one operation per valid/ready handshake and decodes the 4-bit function code into a one-cycle enable for exactly one execution unit (arith, logic, compare, shift). It then waits for that unit's completion flag, captures the unit result and returns it through a valid/ready result port. The block is the initiator to the units, which all follow the same enable-in / registered result + flag-out convention as the shift unit.

## Interface
- A_width, 16, operand A width
- B_width, 16, operand B width
- OUT_width, 32, result width; each unit result port is OUT_width, narrower units zero-extended at top level
- TIMEOUT, 8, max WAIT cycles before error completion (≥1)

- CLK_SEQ  in  1  single clock, all logic on rising edge
- RST_SEQ  in  1  synchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command
- CMD_A  in  A_width  operand A
- CMD_B  in  B_width  operand B
- CMD_FUN  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
- A_OUT  out  A_width  registered operand A to units
- B_OUT  out  B_width  registered operand B to units
- FUN_OUT  out  2  registered CMD_FUN[1:0] to units
- ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  out  1 each  unit enables, at most one high
- ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT  in  OUT_width each  unit results
- ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  in  1 each  unit completion flags
- RES_VALID  out  1  result available
- RES_READY  in  1  consumer takes result
- RES_DATA  out  OUT_width  captured result
- RES_ERR  out  1  result is a timeout completion
- ERR_CNT  out  8  saturating count of timeout completions

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, the following happen at the same edge:
  - Register CMD_A→A_OUT, CMD_B→B_OUT, CMD_FUN[1:0]→FUN_OUT.
  - Latch unit select.
  - Go to ISSUE.
- ISSUE: one cycle. Assert the selected unit's EN. Clear the wait counter. Go to WAIT.
- WAIT: all ENs low. Only the selected unit's FLAG is observed.
  - If FLAG=1: RES_DATA ← selected unit OUT, RES_ERR ← 0, go to DONE.
  - Else if counter = TIMEOUT−1: RES_DATA ← 0, RES_ERR ← 1, ERR_CNT += 1 (saturates at 255), go to DONE.
  - Else counter += 1.
  - When FLAG and the timeout occur in the same cycle, FLAG wins.
- DONE: RES_VALID=1. RES_DATA and RES_ERR are held stable. On RES_READY go to IDLE.
- The sequencer never observes flags outside WAIT. A stale unit flag left high from a prior op coincides with fresh data, because the unit registers on the ISSUE cycle.
- A_OUT, B_OUT and FUN_OUT hold their values until the next accepted command.
- Reset (RST_SEQ=0 at any edge, in any state): go to IDLE. Reset values:
  - A_OUT, B_OUT, FUN_OUT: 0
  - All ENs: 0
  - RES_VALID, RES_DATA, RES_ERR: 0
  - ERR_CNT: 0
  - Wait counter: 0
  - CMD_READY is gated low while RST_SEQ=0.
  - Any in-flight op is discarded and no result is produced.

## Timing
- All outputs are registered except CMD_READY, which is (state==IDLE)&RST_SEQ.
- Accept edge E0 → EN high for the cycle after E0 → WAIT from E1 → RES_VALID high after E2, for a unit whose flag is valid one edge after EN.
- Minimum command-to-result latency: 2 edges after accept.
- Minimum throughput: 1 op per 4 cycles when RES_READY=1 at first DONE cycle. RES_READY held high in DONE → IDLE next edge. CMD_READY returns one cycle later; no accept occurs in the DONE cycle.
- Timeout completion: RES_VALID high TIMEOUT+1 edges after accept edge.
- RES_VALID stays high until RES_READY is sampled high. Backpressure is unbounded.
- CMD_VALID outside IDLE is ignored. Command inputs are sampled only on the accept edge.

## Test plan
- Reset then shift op: CMD_FUN=4'b1101, CMD_A=16'h00F0. SHIFT_EN is high for exactly 1 cycle with FUN_OUT=01, and no other EN is high. The unit model returns 16'h01E0 with flag one edge later. RES_VALID rises 2 edges after accept with RES_DATA=32'h000001E0 and RES_ERR=0.
- Back-to-back arith (0000), logic (0110), cmp (1001), each with RES_READY tied high: each op produces exactly one matching EN pulse and one result. CMD_READY is low from accept until the cycle after DONE.
- Timeout: select logic, LOGIC_FLAG held 0, TIMEOUT=8. RES_VALID appears 9 edges after accept with RES_DATA=0, RES_ERR=1, and ERR_CNT increments 0→1. Flag asserted on the last WAIT cycle instead gives RES_ERR=0.
- Backpressure: RES_READY=0 for 10 cycles in DONE. RES_DATA and RES_ERR stay stable, CMD_VALID pulses are ignored, and the result is released on the cycle RES_READY=1.
- Reset mid-op: RST_SEQ=0 during WAIT. On the next edge all outputs reach their reset values and the state is IDLE. After release, a new command completes normally and no stale result appears.
- ERR_CNT saturation: 256 consecutive timeouts leave ERR_CNT=255.
